// File: rtl/display_scan_decoder.sv
// display_scan_decoder
//   Receive end of the ARC display bus.  One word of NDIG digit slots follows
//   each START strobe; each slot is BITS_PER_DIGIT PHI2 cycles long and DD is
//   sampled in the slot's last cycle.  Digits collect in a shadow buffer.
//   They are copied to the display buffer only when the final digit arrives,
//   so the scan never shows a half-received word.  The display buffer is
//   multiplexed onto a 7-segment LED scan, one digit per SCAN_DIV cycles.
//
// Ports
//   PHI2        in   clock, all state updates on the rising edge
//   PWO         in   synchronous active-high reset
//   DD[4:0]     in   display bus {E = decimal point, D,C,B,A = BCD 3..0}
//   START       in   one-cycle word-start strobe
//   seg_out     out  segments {g,f,e,d,c,b,a}, active high
//   dp_out      out  decimal point of the scanned digit
//   dig_idx     out  index of the scanned digit, 0..NDIG-1
//   dig_en      out  digit driver enable
//   frame_valid out  a committed frame is held and displayed
//   sync_err    out  one-cycle pulse, START arrived before the word completed
//   dbg_state   out  capture FSM state (00 IDLE, 01 CAPTURE, 10 HOLD)
module display_scan_decoder #(
   parameter int NDIG           = 14,
   parameter int BITS_PER_DIGIT = 4,
   parameter int SCAN_DIV       = 64,
   parameter int TIMEOUT_WORDS  = 4
) (
   input  logic       PHI2,
   input  logic       PWO,
   input  logic [4:0] DD,
   input  logic       START,
   output logic [6:0] seg_out,
   output logic       dp_out,
   output logic [3:0] dig_idx,
   output logic       dig_en,
   output logic       frame_valid,
   output logic       sync_err,
   output logic [1:0] dbg_state
);

   localparam int WORD_LEN = NDIG * BITS_PER_DIGIT;
   localparam int CNT_W    = $clog2(WORD_LEN);
   localparam int SLOT_W   = $clog2(BITS_PER_DIGIT);
   localparam int TO_LIMIT = TIMEOUT_WORDS * WORD_LEN;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam int SD_W     = $clog2(SCAN_DIV);

   // Blank digit: code 4'hF decodes to no segments, decimal point off.
   localparam logic [4:0] BLANK = 5'h0F;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CAPTURE = 2'b01,
      HOLD    = 2'b10
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [TO_W-1:0]   tcnt;
   logic [SD_W-1:0]   sdiv;
   logic [4:0]        shadow [NDIG];
   logic [4:0]        disp   [NDIG];
   logic [6:0]        seg_reg;
   logic              dp_reg;
   logic              commit;
   logic              err_nx;
   logic              timeout_hit;
   logic              slot_last;
   logic [CNT_W-SLOT_W-1:0] slot;

   assign slot_last = (cnt[SLOT_W-1:0] == SLOT_W'(BITS_PER_DIGIT - 1));
   assign slot      = cnt[CNT_W-1:SLOT_W];

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      case (code)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         4'hE:    return 7'h40;
         default: return 7'h00;
      endcase
   endfunction

   // Capture FSM next state.  In IDLE/HOLD cnt rests at 0, so the START
   // cycle itself is cnt 0 and the next cycle is cnt 1.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no path
      // leaves one unassigned and infers a latch.
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      err_nx   = 1'b0;
      case (state)
         IDLE, HOLD: begin
            if (START) begin
               state_nx = CAPTURE;
               cnt_nx   = CNT_W'(1);
            end
         end
         CAPTURE: begin
            if (cnt == CNT_W'(WORD_LEN - 1)) begin
               // Last digit still commits even if a new START collides with it;
               // the new word's cnt 0 is then the following cycle.
               commit = 1'b1;
               cnt_nx = '0;
               if (START) err_nx   = 1'b1;
               else       state_nx = HOLD;
            end else if (START) begin
               // Early START: drop the partial word; this cycle is cnt 0.
               err_nx = 1'b1;
               cnt_nx = CNT_W'(1);
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      // A commit clears the timeout, so the two never coincide.
      timeout_hit = !commit && (tcnt == TO_W'(TO_LIMIT - 1));
      if (timeout_hit) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end
   end

   // Capture datapath, commit and timeout.
   always_ff @(posedge PHI2) begin
      if (PWO) begin
         state       <= IDLE;
         cnt         <= '0;
         tcnt        <= '0;
         sync_err    <= 1'b0;
         frame_valid <= 1'b0;
         // NOTE: both buffers are reset explicitly because a blank display is
         // required after reset; a plain storage array would not need this.
         for (int i = 0; i < NDIG; i++) begin
            shadow[i] <= BLANK;
            disp[i]   <= BLANK;
         end
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the pre-edge values of the others regardless of statement order.
         state    <= state_nx;
         cnt      <= cnt_nx;
         sync_err <= err_nx;

         if (state == CAPTURE && slot_last)
            shadow[slot] <= DD;

         if (commit) begin
            // The final digit is sampled in the commit cycle, so take it from
            // DD directly rather than from the shadow slot written in parallel.
            for (int i = 0; i < NDIG - 1; i++)
               disp[i] <= shadow[i];
            disp[NDIG-1] <= DD;
            frame_valid  <= 1'b1;
            tcnt         <= '0;
         end else begin
            if (tcnt != TO_W'(TO_LIMIT))
               tcnt <= tcnt + TO_W'(1);
            if (timeout_hit) begin
               frame_valid <= 1'b0;
               for (int i = 0; i < NDIG; i++)
                  disp[i] <= BLANK;
            end
         end
      end
   end

   // LED scan: divider, digit index and registered decode.  The decode lags
   // dig_idx by one cycle, which lands inside the blanked divider count 0.
   always_ff @(posedge PHI2) begin
      if (PWO) begin
         sdiv    <= '0;
         dig_idx <= '0;
         seg_reg <= '0;
         dp_reg  <= 1'b0;
      end else begin
         if (sdiv == SD_W'(SCAN_DIV - 1)) begin
            sdiv    <= '0;
            dig_idx <= (dig_idx == 4'(NDIG - 1)) ? 4'd0 : dig_idx + 4'd1;
         end else begin
            sdiv <= sdiv + SD_W'(1);
         end
         seg_reg <= seg_decode(disp[dig_idx][3:0]);
         dp_reg  <= disp[dig_idx][4];
      end
   end

   assign dig_en    = frame_valid && (sdiv != '0);
   assign seg_out   = dig_en ? seg_reg : 7'h00;
   assign dp_out    = dig_en & dp_reg;
   assign dbg_state = state;

endmodule
